vga_temporizador: RTL and testbench

VGA_TEMPORIZADOR -- requirements
Module: vga_temporizador

---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_atraso.sv | 30 +++
 rtl/vga_temporizador.sv | 95 +++++++++
 tb/tb_vga_temporizador.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz defaults) and the sync bundle type.
package vga_pkg;

    localparam int unsigned VGA_LARGURA = 10;

    localparam int unsigned H_ATIVO_PAD = 640;
    localparam int unsigned H_FP_PAD    = 16;
    localparam int unsigned H_SYNC_PAD  = 96;
    localparam int unsigned H_BP_PAD    = 48;
    localparam int unsigned V_ATIVO_PAD = 480;
    localparam int unsigned V_FP_PAD    = 10;
    localparam int unsigned V_SYNC_PAD  = 2;
    localparam int unsigned V_BP_PAD    = 33;

    localparam int unsigned H_TOTAL_PAD = H_ATIVO_PAD + H_FP_PAD + H_SYNC_PAD + H_BP_PAD;
    localparam int unsigned V_TOTAL_PAD = V_ATIVO_PAD + V_FP_PAD + V_SYNC_PAD + V_BP_PAD;

    // Active-window bounds in raw counter coordinates; renderers subtract X_INICIO/Y_INICIO.
    localparam int unsigned X_INICIO = H_SYNC_PAD + H_BP_PAD;
    localparam int unsigned X_FIM    = X_INICIO + H_ATIVO_PAD;
    localparam int unsigned Y_INICIO = V_SYNC_PAD + V_BP_PAD;
    localparam int unsigned Y_FIM    = Y_INICIO + V_ATIVO_PAD;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } vga_sinc_t;

    localparam int unsigned SINC_LARGURA = $bits(vga_sinc_t);

    // Idle bundle value: hs=1, vs=1, blank_n=0.
    localparam logic [SINC_LARGURA-1:0] SINC_RESET = 3'b110;

endpackage

// File: rtl/vga_atraso.sv
// Fixed-depth register chain with per-bit reset values; depth 0 is a plain wire.
module vga_atraso #(
    parameter int unsigned          LARGURA      = 3,
    parameter int unsigned          PROFUNDIDADE = 1,
    parameter logic [LARGURA-1:0]   VALOR_RESET  = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LARGURA-1:0] entrada,
    output logic [LARGURA-1:0] saida
);

    if (PROFUNDIDADE == 0) begin : g_direto
        assign saida = entrada;
    end else begin : g_cadeia
        logic [LARGURA-1:0] estagio [PROFUNDIDADE];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(PROFUNDIDADE); i++) estagio[i] <= VALOR_RESET;
            end else begin
                estagio[0] <= entrada;
                for (int i = 1; i < int'(PROFUNDIDADE); i++) estagio[i] <= estagio[i-1];
            end
        end

        assign saida = estagio[PROFUNDIDADE-1];
    end

endmodule

// File: rtl/vga_temporizador.sv
// VGA raster timing: h/v counters, sync/blank generation aligned to the colour pipeline,
// frame-start pulse and an 8-bit frame counter for animation.
module vga_temporizador
    import vga_pkg::*;
#(
    parameter int unsigned H_ATIVO = H_ATIVO_PAD,
    parameter int unsigned H_FP    = H_FP_PAD,
    parameter int unsigned H_SYNC  = H_SYNC_PAD,
    parameter int unsigned H_BP    = H_BP_PAD,
    parameter int unsigned V_ATIVO = V_ATIVO_PAD,
    parameter int unsigned V_FP    = V_FP_PAD,
    parameter int unsigned V_SYNC  = V_SYNC_PAD,
    parameter int unsigned V_BP    = V_BP_PAD,
    parameter int unsigned ATRASO  = 1
) (
    input  logic                   VGA_CLK,
    input  logic                   reset_n,
    output logic [VGA_LARGURA-1:0] VGA_X,
    output logic [VGA_LARGURA-1:0] VGA_Y,
    output logic                   VGA_HS,
    output logic                   VGA_VS,
    output logic                   VGA_BLANK_N,
    output logic                   VGA_SYNC_N,
    output logic                   inicio_quadro,
    output logic [7:0]             contador_quadros
);

    localparam logic [VGA_LARGURA-1:0] H_ULTIMO = VGA_LARGURA'(H_ATIVO + H_FP + H_SYNC + H_BP - 1);
    localparam logic [VGA_LARGURA-1:0] V_ULTIMO = VGA_LARGURA'(V_ATIVO + V_FP + V_SYNC + V_BP - 1);
    localparam logic [VGA_LARGURA-1:0] H_SINC   = VGA_LARGURA'(H_SYNC);
    localparam logic [VGA_LARGURA-1:0] V_SINC   = VGA_LARGURA'(V_SYNC);
    localparam logic [VGA_LARGURA-1:0] H_INI    = VGA_LARGURA'(H_SYNC + H_BP);
    localparam logic [VGA_LARGURA-1:0] H_FIM    = VGA_LARGURA'(H_SYNC + H_BP + H_ATIVO);
    localparam logic [VGA_LARGURA-1:0] V_INI    = VGA_LARGURA'(V_SYNC + V_BP);
    localparam logic [VGA_LARGURA-1:0] V_FIM    = VGA_LARGURA'(V_SYNC + V_BP + V_ATIVO);

    logic [VGA_LARGURA-1:0] h;
    logic [VGA_LARGURA-1:0] v;
    logic [VGA_LARGURA-1:0] h_prox;
    logic [VGA_LARGURA-1:0] v_prox;
    vga_sinc_t              bruto;
    vga_sinc_t              atrasado;

    // Next raster position; v only moves on an h wrap.
    always_comb begin
        h_prox = h + VGA_LARGURA'(1);
        v_prox = v;
        if (h == H_ULTIMO) begin
            h_prox = '0;
            v_prox = (v == V_ULTIMO) ? '0 : v + VGA_LARGURA'(1);
        end
    end

    // The frame pulse is decoded from the next position so it lines up with VGA_X=0.
    always_ff @(posedge VGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            h                <= '0;
            v                <= '0;
            inicio_quadro    <= 1'b0;
            contador_quadros <= '0;
        end else begin
            h             <= h_prox;
            v             <= v_prox;
            inicio_quadro <= (h_prox == '0) && (v_prox == V_FIM);
            if (inicio_quadro) contador_quadros <= contador_quadros + 8'd1;
        end
    end

    always_comb begin
        bruto         = '0;
        bruto.hs      = !(h < H_SINC);
        bruto.vs      = !(v < V_SINC);
        bruto.blank_n = (h >= H_INI) && (h < H_FIM) && (v >= V_INI) && (v < V_FIM);
    end

    // Matches the renderer's colour latency so sync/blank stay aligned with pixels.
    vga_atraso #(
        .LARGURA      (SINC_LARGURA),
        .PROFUNDIDADE (ATRASO),
        .VALOR_RESET  (SINC_RESET)
    ) u_atraso (
        .clk     (VGA_CLK),
        .rst_n   (reset_n),
        .entrada (bruto),
        .saida   (atrasado)
    );

    assign VGA_X       = h;
    assign VGA_Y       = v;
    assign VGA_HS      = atrasado.hs;
    assign VGA_VS      = atrasado.vs;
    assign VGA_BLANK_N = atrasado.blank_n;
    assign VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_temporizador.sv
// Directed bench for vga_temporizador: default timing at ATRASO 0/1/3 plus a shrunken
// timing instance for frame-level behaviour (frame pulse, counter wrap, mid-frame reset).
module tb_vga_temporizador;

    // Shrunken raster: 13 clocks/line, 10 lines/frame, active h 4..11, v 3..8, frame pulse at v=9.
    localparam int unsigned P_H_ATIVO = 8, P_H_FP = 1, P_H_SYNC = 2, P_H_BP = 2;
    localparam int unsigned P_V_ATIVO = 6, P_V_FP = 1, P_V_SYNC = 1, P_V_BP = 2;
    localparam int unsigned P_QUADRO  = 130;

    if ((P_H_ATIVO + P_H_FP + P_H_SYNC + P_H_BP > 1023) ||
        (P_V_ATIVO + P_V_FP + P_V_SYNC + P_V_BP > 1023) ||
        (640 + 16 + 96 + 48 > 1023) || (480 + 10 + 2 + 33 > 1023)) begin : g_param_invalido
        $error("timing parameter sum exceeds 10-bit counter range");
    end

    logic clk = 1'b0;
    logic rst_d = 1'b0;
    logic rst_p = 1'b0;

    always #5 clk = ~clk;

    logic [9:0] x_d, y_d, x_0, y_0, x_3, y_3, x_p, y_p;
    logic       hs_d, vs_d, bl_d, sn_d, ini_d;
    logic       hs_0, vs_0, bl_0, sn_0, ini_0;
    logic       hs_3, vs_3, bl_3, sn_3, ini_3;
    logic       hs_p, vs_p, bl_p, sn_p, ini_p;
    logic [7:0] cnt_d, cnt_0, cnt_3, cnt_p;

    vga_temporizador #(.ATRASO(1)) dut_d (
        .VGA_CLK(clk), .reset_n(rst_d), .VGA_X(x_d), .VGA_Y(y_d), .VGA_HS(hs_d), .VGA_VS(vs_d),
        .VGA_BLANK_N(bl_d), .VGA_SYNC_N(sn_d), .inicio_quadro(ini_d), .contador_quadros(cnt_d));

    vga_temporizador #(.ATRASO(0)) dut_0 (
        .VGA_CLK(clk), .reset_n(rst_d), .VGA_X(x_0), .VGA_Y(y_0), .VGA_HS(hs_0), .VGA_VS(vs_0),
        .VGA_BLANK_N(bl_0), .VGA_SYNC_N(sn_0), .inicio_quadro(ini_0), .contador_quadros(cnt_0));

    vga_temporizador #(.ATRASO(3)) dut_3 (
        .VGA_CLK(clk), .reset_n(rst_d), .VGA_X(x_3), .VGA_Y(y_3), .VGA_HS(hs_3), .VGA_VS(vs_3),
        .VGA_BLANK_N(bl_3), .VGA_SYNC_N(sn_3), .inicio_quadro(ini_3), .contador_quadros(cnt_3));

    vga_temporizador #(
        .H_ATIVO(P_H_ATIVO), .H_FP(P_H_FP), .H_SYNC(P_H_SYNC), .H_BP(P_H_BP),
        .V_ATIVO(P_V_ATIVO), .V_FP(P_V_FP), .V_SYNC(P_V_SYNC), .V_BP(P_V_BP), .ATRASO(1)
    ) dut_p (
        .VGA_CLK(clk), .reset_n(rst_p), .VGA_X(x_p), .VGA_Y(y_p), .VGA_HS(hs_p), .VGA_VS(vs_p),
        .VGA_BLANK_N(bl_p), .VGA_SYNC_N(sn_p), .inicio_quadro(ini_p), .contador_quadros(cnt_p));

    int total  = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    int bad_x, hs_low, hs_first, vs_low, y_799, y_800, sn_bad;
    int b0_x, b0_y, b1_x, b1_y, b3_x, b3_y, hs3_first;
    int pvs_low, pbl_cnt, pb_x, pb_y, np, pos_bad;
    int pulso_n [3];
    int cont_lido [3];
    int achou, run, max_run, wrap_seen, wrap_x, wrap_y, apos_cnt, apos_ini;
    logic prev_ini;

    initial begin
        bad_x = 0; hs_low = 0; hs_first = -1; vs_low = 0; y_799 = -1; y_800 = -1; sn_bad = 0;
        b0_x = -1; b0_y = -1; b1_x = -1; b1_y = -1; b3_x = -1; b3_y = -1; hs3_first = -1;
        pvs_low = 0; pbl_cnt = 0; pb_x = -1; pb_y = -1; np = 0; pos_bad = 0;
        pulso_n = '{-1, -1, -1}; cont_lido = '{-1, -1, -1};
        achou = 0; run = 0; max_run = 0; wrap_seen = 0; wrap_x = -1; wrap_y = -1;
        apos_cnt = -1; apos_ini = -1; prev_ini = 1'b0;

        // Reset values while held in reset
        repeat (3) @(negedge clk);
        chk("rst_x",      32'(x_d), 32'd0);
        chk("rst_y",      32'(y_d), 32'd0);
        chk("rst_hs",     32'(hs_d), 32'd1);
        chk("rst_vs",     32'(vs_d), 32'd1);
        chk("rst_blank",  32'(bl_d), 32'd0);
        chk("rst_sync_n", 32'(sn_d), 32'd0);
        chk("rst_inicio", 32'(ini_d), 32'd0);
        chk("rst_cont",   32'(cnt_d), 32'd0);
        chk("rst_hs_a3",  32'(hs_3), 32'd1);
        chk("rst_bl_a3",  32'(bl_3), 32'd0);

        // Default timing: first line, vertical sync, blank start on line 35
        rst_d = 1'b1;
        @(posedge clk); #1;
        chk("x_first_edge", 32'(x_d), 32'd1);
        for (int n = 1; n <= 28200; n++) begin
            @(negedge clk);
            if (n <= 800) begin
                if (x_d !== 10'(n % 800)) bad_x++;
                if (n == 799) y_799 = int'(y_d);
                if (n == 800) y_800 = int'(y_d);
                if (hs_d === 1'b0) begin
                    hs_low++;
                    if (hs_first < 0) hs_first = int'(x_d);
                end
                if (hs_3 === 1'b0 && hs3_first < 0) hs3_first = int'(x_3);
            end
            if (vs_d === 1'b0) vs_low++;
            if (sn_d !== 1'b0) sn_bad++;
            if (bl_0 === 1'b1 && b0_x < 0) begin b0_x = int'(x_0); b0_y = int'(y_0); end
            if (bl_d === 1'b1 && b1_x < 0) begin b1_x = int'(x_d); b1_y = int'(y_d); end
            if (bl_3 === 1'b1 && b3_x < 0) begin b3_x = int'(x_3); b3_y = int'(y_3); end
        end
        chk("x_sequence_errors", 32'(bad_x), 32'd0);
        chk("y_before_wrap",     32'(y_799), 32'd0);
        chk("y_after_wrap",      32'(y_800), 32'd1);
        chk("hs_low_cycles",     32'(hs_low), 32'd96);
        chk("hs_first_low_x",    32'(hs_first), 32'd1);
        chk("hs_a3_first_low_x", 32'(hs3_first), 32'd3);
        chk("vs_low_cycles",     32'(vs_low), 32'd1600);
        chk("sync_n_nonzero",    32'(sn_bad), 32'd0);
        chk("blank_a0_x",        32'(b0_x), 32'd144);
        chk("blank_a0_y",        32'(b0_y), 32'd35);
        chk("blank_a1_x",        32'(b1_x), 32'd145);
        chk("blank_a1_y",        32'(b1_y), 32'd35);
        chk("blank_a3_x",        32'(b3_x), 32'd147);
        chk("blank_a3_y",        32'(b3_y), 32'd35);

        // Shrunken timing: one full frame of stats plus three frame pulses
        chk("p_rst_x", 32'(x_p), 32'd0);
        @(negedge clk);
        rst_p = 1'b1;
        @(posedge clk); #1;
        chk("p_x_first_edge", 32'(x_p), 32'd1);
        for (int n = 1; n <= 395; n++) begin
            @(negedge clk);
            if (n <= int'(P_QUADRO)) begin
                if (vs_p === 1'b0) pvs_low++;
                if (bl_p === 1'b1) begin
                    pbl_cnt++;
                    if (pb_x < 0) begin pb_x = int'(x_p); pb_y = int'(y_p); end
                end
            end
            if (prev_ini && np >= 1 && np <= 3) cont_lido[np-1] = int'(cnt_p);
            if (ini_p === 1'b1) begin
                if (np < 3) pulso_n[np] = n;
                np++;
                if (x_p !== 10'd0 || y_p !== 10'd9) pos_bad++;
            end
            prev_ini = ini_p;
        end
        chk("p_vs_low_cycles", 32'(pvs_low), 32'd13);
        chk("p_blank_cycles",  32'(pbl_cnt), 32'd48);
        chk("p_blank_first_x", 32'(pb_x), 32'd5);
        chk("p_blank_first_y", 32'(pb_y), 32'd3);
        chk("p_pulse_count",   32'(np), 32'd3);
        chk("p_pulse_first_n", 32'(pulso_n[0]), 32'd117);
        chk("p_pulse_gap_1",   32'(pulso_n[1] - pulso_n[0]), 32'(P_QUADRO));
        chk("p_pulse_gap_2",   32'(pulso_n[2] - pulso_n[1]), 32'(P_QUADRO));
        chk("p_pulse_pos_bad", 32'(pos_bad), 32'd0);
        chk("p_cont_1",        32'(cont_lido[0]), 32'd1);
        chk("p_cont_2",        32'(cont_lido[1]), 32'd2);
        chk("p_cont_3",        32'(cont_lido[2]), 32'd3);

        // Asynchronous reset in the middle of the active window
        for (int k = 0; k < 200 && achou == 0; k++) begin
            @(negedge clk);
            if (x_p == 10'd7 && y_p == 10'd5) achou = 1;
        end
        chk("p_reached_7_5", 32'(achou), 32'd1);
        chk("p_blank_pre_rst", 32'(bl_p), 32'd1);
        #2 rst_p = 1'b0;
        #1;
        chk("p_async_x",      32'(x_p), 32'd0);
        chk("p_async_y",      32'(y_p), 32'd0);
        chk("p_async_hs",     32'(hs_p), 32'd1);
        chk("p_async_vs",     32'(vs_p), 32'd1);
        chk("p_async_blank",  32'(bl_p), 32'd0);
        chk("p_async_inicio", 32'(ini_p), 32'd0);
        chk("p_async_cont",   32'(cnt_p), 32'd0);
        chk("p_async_sync_n", 32'(sn_p), 32'd0);
        @(negedge clk);
        rst_p = 1'b1;
        @(posedge clk); #1;
        chk("p_x_after_rst", 32'(x_p), 32'd1);

        // Frame counter wrap after 256 frames; pulse must stay one cycle wide
        for (int k = 0; k < 34000; k++) begin
            @(negedge clk);
            if (ini_p === 1'b1) begin
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (wrap_seen != 0) begin
                apos_cnt = int'(cnt_p);
                apos_ini = int'(ini_p);
                break;
            end
            if (ini_p === 1'b1 && cnt_p == 8'd255) begin
                wrap_seen = 1;
                wrap_x = int'(x_p);
                wrap_y = int'(y_p);
            end
        end
        chk("p_wrap_seen",    32'(wrap_seen), 32'd1);
        chk("p_wrap_x",       32'(wrap_x), 32'd0);
        chk("p_wrap_y",       32'(wrap_y), 32'd9);
        chk("p_wrap_cont",    32'(apos_cnt), 32'd0);
        chk("p_wrap_ini_off", 32'(apos_ini), 32'd0);
        chk("p_pulse_width",  32'(max_run), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
